// File: rtl/bw_io_dtl_flps_bank.sv
// Scan-flop bank for DTL pad control/data bits: capture flops stitched into a scan chain,
// an optional shadow update stage, a 1-bit scan bypass and a shift-complete pulse.

module bw_io_dtl_flps_cell #(
   parameter bit RV  = 1'b0,
   parameter bit UPD = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic shift,
   input  logic load,
   input  logic upd_ld,
   input  logic sin,
   input  logic d,
   output logic cap,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cap <= RV;
      else if (shift) cap <= sin;
      else if (load)  cap <= d;
   end

   generate
      if (UPD) begin : g_upd
         logic upd_r;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)         upd_r <= RV;
            else if (upd_ld) upd_r <= cap;
         end
         assign q = upd_r;
      end else begin : g_noupd
         assign q = cap;
      end
   endgenerate

endmodule

module bw_io_dtl_flps_bank #(
   parameter int               WIDTH     = 3,
   parameter bit               UPD_STAGE = 1'b1,
   parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             se,
   input  logic             si,
   input  logic             bypass,
   input  logic             upd,
   output logic [WIDTH-1:0] q,
   output logic             so,
   output logic             shift_done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

   logic             shift, load, upd_ld, byp;
   logic [WIDTH-1:0] cap, sin_v;
   logic [CW-1:0]    cnt;

   assign shift  = se & ~bypass;
   assign load   = ~se & en;
   // upd is blocked while shifting so the pads never see a half-shifted chain
   assign upd_ld = upd & ~se;
   assign sin_v  = {cap[WIDTH-2:0], si};

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         bw_io_dtl_flps_cell #(.RV(RST_VAL[i]), .UPD(UPD_STAGE)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .shift  (shift),
            .load   (load),
            .upd_ld (upd_ld),
            .sin    (sin_v[i]),
            .d      (d[i]),
            .cap    (cap[i]),
            .q      (q[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                byp <= 1'b0;
      else if (se && bypass)  byp <= si;
   end

   assign so = bypass ? byp : cap[WIDTH-1];

   // bypass shifts freeze the count; dropping se discards a partial chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         shift_done <= 1'b0;
      end else if (shift) begin
         if (cnt == CMAX) begin
            cnt        <= '0;
            shift_done <= 1'b1;
         end else begin
            cnt        <= cnt + 1'b1;
            shift_done <= 1'b0;
         end
      end else begin
         if (!se) cnt <= '0;
         shift_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bw_io_dtl_flps_bank.sv
// Directed bench: WIDTH=3/RST_VAL=101 with update stage, and WIDTH=8 without update stage.

module tb_bw_io_dtl_flps_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] d3 = '0;
   logic       en3 = 0, se3 = 0, si3 = 0, bp3 = 0, upd3 = 0;
   logic [2:0] q3;
   logic       so3, sd3;
   logic [7:0] d8 = '0;
   logic       en8 = 0, se8 = 0, si8 = 0, bp8 = 0, upd8 = 0;
   logic [7:0] q8;
   logic       so8, sd8;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bw_io_dtl_flps_bank #(.WIDTH(3), .UPD_STAGE(1'b1), .RST_VAL(3'b101)) u3 (
      .clk(clk), .rst(rst), .d(d3), .en(en3), .se(se3), .si(si3), .bypass(bp3),
      .upd(upd3), .q(q3), .so(so3), .shift_done(sd3));

   bw_io_dtl_flps_bank #(.WIDTH(8), .UPD_STAGE(1'b0), .RST_VAL(8'h00)) u8 (
      .clk(clk), .rst(rst), .d(d8), .en(en8), .se(se8), .si(si8), .bypass(bp8),
      .upd(upd8), .q(q8), .so(so8), .shift_done(sd8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // async reset mid-cycle
      #3 rst = 1'b1;
      #1;
      chk("rst_q3", q3, 3'b101);
      chk("rst_so3", so3, 1'b1);
      chk("rst_sd3", sd3, 1'b0);
      chk("rst_q8", q8, 8'h00);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_q3", q3, 3'b101);

      // capture without update leaves q alone
      d3 = 3'b110; en3 = 1'b1;
      step();
      en3 = 1'b0; d3 = 3'b000;
      chk("cap_q3_hold", q3, 3'b101);
      chk("cap_so3", so3, 1'b1);
      upd3 = 1'b1;
      step();
      upd3 = 1'b0;
      chk("upd_q3", q3, 3'b110);

      // shift 0,0,1 -> cap = 001
      se3 = 1'b1; si3 = 1'b0;
      step();
      chk("sh1_sd", sd3, 1'b0);
      step();
      chk("sh2_sd", sd3, 1'b0);
      si3 = 1'b1;
      step();
      chk("sh3_so", so3, 1'b0);
      chk("sh3_sd", sd3, 1'b1);
      chk("sh3_q", q3, 3'b110);
      se3 = 1'b0; si3 = 1'b0;
      step();
      chk("sh4_sd", sd3, 1'b0);
      upd3 = 1'b1;
      step();
      upd3 = 1'b0;
      chk("sh_upd_q", q3, 3'b001);

      // bypass path: one-cycle latency, chain untouched
      se3 = 1'b1; bp3 = 1'b1; si3 = 1'b1;
      step();
      chk("byp_so", so3, 1'b1);
      chk("byp_sd", sd3, 1'b0);
      bp3 = 1'b0; se3 = 1'b0; si3 = 1'b0;
      #1;
      chk("byp_cap_so", so3, 1'b0);
      step();

      // bypass mid-shift freezes the count
      se3 = 1'b1;
      step();
      step();
      chk("mid_sd0", sd3, 1'b0);
      bp3 = 1'b1;
      step();
      chk("mid_sd_byp", sd3, 1'b0);
      bp3 = 1'b0;
      step();
      chk("mid_sd_done", sd3, 1'b1);
      se3 = 1'b0;
      step();
      chk("mid_sd_clr", sd3, 1'b0);

      // partial chain: 2 shifts, break, 3 shifts -> one pulse at the end
      se3 = 1'b1;
      step(); chk("pc_a1", sd3, 1'b0);
      step(); chk("pc_a2", sd3, 1'b0);
      se3 = 1'b0;
      step(); chk("pc_brk", sd3, 1'b0);
      se3 = 1'b1;
      step(); chk("pc_b1", sd3, 1'b0);
      step(); chk("pc_b2", sd3, 1'b0);
      step(); chk("pc_b3", sd3, 1'b1);
      se3 = 1'b0;
      step(); chk("pc_end", sd3, 1'b0);

      // reset mid-shift clears the count
      se3 = 1'b1;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rms_q", q3, 3'b101);
      chk("rms_so", so3, 1'b1);
      chk("rms_sd", sd3, 1'b0);
      #1 rst = 1'b0;
      step();
      chk("rms_after", sd3, 1'b0);
      se3 = 1'b0;
      step();

      // WIDTH=8, no update stage
      d8 = 8'hA5; en8 = 1'b1;
      step();
      en8 = 1'b0;
      chk("w8_cap", q8, 8'hA5);
      upd8 = 1'b1;
      step();
      upd8 = 1'b0;
      chk("w8_upd_ign", q8, 8'hA5);
      se8 = 1'b1; si8 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("w8_sd_lo", sd8, 1'b0);
      end
      step();
      chk("w8_sd_hi", sd8, 1'b1);
      chk("w8_q", q8, 8'h00);
      se8 = 1'b0;
      step();
      chk("w8_sd_end", sd8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
